// File: rtl/calc_entry_fsm_if.sv
//------------------------------------------------------------------------------
// calc_entry_fsm_if : key strobe in, operand/operator/display state out.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface calc_entry_fsm_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] save1;
    logic [15:0] save2;
    logic [3:0]  op;
    logic [1:0]  display_state;
    logic        calc_go;

    modport master (
        output key_valid, key_code,
        input  save1, save2, op, display_state, calc_go
    );

    modport slave (
        input  key_valid, key_code,
        output save1, save2, op, display_state, calc_go
    );
endinterface

`default_nettype wire

// File: rtl/calc_entry_fsm.sv
//------------------------------------------------------------------------------
// calc_entry_fsm : keypad entry FSM collecting two BCD operands and an operator.
// Optional backspace key (0xD) enabled by defining CALC_BACKSPACE_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module calc_entry_fsm #(
    parameter int MAX_DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    calc_entry_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        S_OP1   = 2'b00,
        S_OPSEL = 2'b01,
        S_OP2   = 2'b10,
        S_RES   = 2'b11
    } state_t;

    localparam logic [2:0] C_MAX = 3'(MAX_DIGITS);

    state_t      r_state, w_state;
    logic [15:0] r_save1, w_save1;
    logic [15:0] r_save2, w_save2;
    logic [3:0]  r_op,    w_op;
    logic [2:0]  r_cnt1,  w_cnt1;
    logic [2:0]  r_cnt2,  w_cnt2;
    logic        r_go,    w_go;

    logic w_is_digit;
    logic w_is_op;

    assign w_is_digit = (bus.key_code <= 4'h9);
    assign w_is_op    = (bus.key_code == 4'hA) || (bus.key_code == 4'hB) ||
                        (bus.key_code == 4'hC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OP1;
            r_save1 <= 16'h0000;
            r_save2 <= 16'h0000;
            r_op    <= 4'h0;
            r_cnt1  <= 3'd0;
            r_cnt2  <= 3'd0;
            r_go    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_save1 <= w_save1;
            r_save2 <= w_save2;
            r_op    <= w_op;
            r_cnt1  <= w_cnt1;
            r_cnt2  <= w_cnt2;
            r_go    <= w_go;
        end
    end

    always_comb begin
        w_state = r_state;
        w_save1 = r_save1;
        w_save2 = r_save2;
        w_op    = r_op;
        w_cnt1  = r_cnt1;
        w_cnt2  = r_cnt2;
        w_go    = 1'b0;

        if (bus.key_valid) begin
            if (bus.key_code == 4'hF) begin
                w_state = S_OP1;
                w_save1 = 16'h0000;
                w_save2 = 16'h0000;
                w_op    = 4'h0;
                w_cnt1  = 3'd0;
                w_cnt2  = 3'd0;
            end else begin
                case (r_state)
                    S_OP1: begin
                        if (w_is_digit) begin
                            if (r_cnt1 < C_MAX) begin
                                w_save1 = {r_save1[11:0], bus.key_code};
                                w_cnt1  = r_cnt1 + 3'd1;
                            end
                        end else if (w_is_op) begin
                            w_op    = bus.key_code;
                            w_state = S_OPSEL;
                        end
`ifdef CALC_BACKSPACE_EN
                        else if (bus.key_code == 4'hD && r_cnt1 != 3'd0) begin
                            w_save1 = {4'h0, r_save1[15:4]};
                            w_cnt1  = r_cnt1 - 3'd1;
                        end
`endif
                    end
                    S_OPSEL: begin
                        if (w_is_op) begin
                            w_op = bus.key_code;
                        end else if (w_is_digit) begin
                            w_save2 = {12'h000, bus.key_code};
                            w_cnt2  = 3'd1;
                            w_state = S_OP2;
                        end
`ifdef CALC_BACKSPACE_EN
                        else if (bus.key_code == 4'hD) begin
                            w_op    = 4'h0;
                            w_state = S_OP1;
                        end
`endif
                    end
                    S_OP2: begin
                        if (w_is_digit) begin
                            if (r_cnt2 < C_MAX) begin
                                w_save2 = {r_save2[11:0], bus.key_code};
                                w_cnt2  = r_cnt2 + 3'd1;
                            end
                        end else if (bus.key_code == 4'hE) begin
                            w_go    = 1'b1;
                            w_state = S_RES;
                        end
`ifdef CALC_BACKSPACE_EN
                        else if (bus.key_code == 4'hD) begin
                            // Erasing the only digit falls back to operator selection.
                            if (r_cnt2 <= 3'd1) begin
                                w_save2 = 16'h0000;
                                w_cnt2  = 3'd0;
                                w_state = S_OPSEL;
                            end else begin
                                w_save2 = {4'h0, r_save2[15:4]};
                                w_cnt2  = r_cnt2 - 3'd1;
                            end
                        end
`endif
                    end
                    default: begin
                        if (w_is_digit) begin
                            w_save1 = {12'h000, bus.key_code};
                            w_save2 = 16'h0000;
                            w_op    = 4'h0;
                            w_cnt1  = 3'd1;
                            w_cnt2  = 3'd0;
                            w_state = S_OP1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.save1         = r_save1;
    assign bus.save2         = r_save2;
    assign bus.op            = r_op;
    assign bus.display_state = r_state;
    assign bus.calc_go       = r_go;

endmodule

`default_nettype wire

// File: doc/calc_entry_fsm.md
CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 Parameter: MAX_DIGITS, default 4; maximum BCD digits per operand, legal range 1..4.
REQ-002 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 key_valid  input  1  single-cycle strobe; key_code is valid in the same cycle.
REQ-005 key_code  input  4  0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD backspace, 0xE equals, 0xF clear.
REQ-006 save1  output  16  first operand, packed BCD, least significant digit in bits [3:0].
REQ-007 save2  output  16  second operand, packed BCD, same format as save1.
REQ-008 op  output  4  selected operator code (0xA/0xB/0xC); 0x0 when no operator is selected.
REQ-009 display_state  output  2  display selector: 00 save1, 01 op, 10 save2, 11 result.
REQ-010 calc_go  output  1  single-cycle pulse requesting the downstream ALU to evaluate save1 op save2.

Function
REQ-011 All outputs SHALL be registered; a key sampled at edge N SHALL be visible on the outputs after edge N.
REQ-012 States SHALL be S_OP1, S_OPSEL, S_OP2 and S_RES; display_state SHALL equal 00, 01, 10 and 11 respectively.
REQ-013 Key codes presented while key_valid is low SHALL be ignored.
REQ-014 Digit entry SHALL shift the operand: operand <= {operand[11:0], digit}; each operand has a 3-bit digit counter.
REQ-015 A digit SHALL be ignored when the counter equals MAX_DIGITS (no wrap, no change).
REQ-016 Leading zeros SHALL count as digits.
REQ-017 S_OP1 transitions:
  - digit: shift into save1.
  - 0xA/0xB/0xC: latch op, go to S_OPSEL.
  - 0xE: ignored.
REQ-018 S_OPSEL transitions:
  - 0xA/0xB/0xC: replace op.
  - digit: save2 <= digit, counter2 <= 1, go to S_OP2.
  - 0xE: ignored.
REQ-019 S_OP2 transitions:
  - digit: shift into save2.
  - 0xA/0xB/0xC: ignored.
  - 0xE: assert calc_go for exactly one cycle, go to S_RES.
REQ-020 S_RES transitions:
  - digit: save1 <= digit, save2 <= 0, op <= 0, counters 1/0, go to S_OP1.
  - 0xA/0xB/0xC/0xE: ignored.
  - save1, save2 and op SHALL hold in S_RES.
REQ-021 Key 0xF in any state SHALL clear save1, save2, op and both counters, deassert calc_go, and enter S_OP1.
REQ-022 calc_go SHALL be 0 in every cycle except the single cycle following the accepted 0xE edge.

Reset
REQ-023 When rst is high at a rising edge, the block SHALL enter S_OP1 with the following values:
  - save1 = 0x0000, save2 = 0x0000, op = 0x0
  - display_state = 00, calc_go = 0, counters = 0
REQ-024 rst SHALL take priority over a simultaneous key_valid; that key SHALL be lost.
REQ-025 Reset asserted mid-entry, or in the cycle calc_go is high, SHALL abort the entry, with calc_go low after the edge.

Configuration
REQ-026 Macro CALC_BACKSPACE_EN SHALL control the backspace feature.
REQ-027 With CALC_BACKSPACE_EN defined, key 0xD SHALL behave as follows:
  - S_OP1: save1 <= {4'h0, save1[15:4]} and decrement counter1; no action when the counter is 0.
  - S_OP2: the same action applied to save2 and counter2.
  - S_OP2 with counter2 = 1: return to S_OPSEL with save2 = 0.
  - S_OPSEL: op <= 0 and return to S_OP1.
  - S_RES: ignored.
REQ-028 Without CALC_BACKSPACE_EN, key 0xD SHALL be ignored in all states and no backspace logic SHALL be synthesised.

Verification
REQ-029 Reset, then keys 1,2,3 -> save1 = 0x0123, display_state = 00, calc_go = 0.
REQ-030 Keys 4,5,6,7,8 -> save1 = 0x4567 (5th digit dropped); then 0xB,0x9,0xE -> op = 0xB, save2 = 0x0009, calc_go is a single 1-cycle pulse, display_state = 11.
REQ-031 Keys 0x2,0xA,0xC,0x7 -> op = 0xC, save2 = 0x0007, display_state = 10; 0xE while in S_OPSEL produces no calc_go.
REQ-032 Key 0xF in S_OP2 with save2 = 0x0042 -> all operands 0, op = 0, display_state = 00 on the next cycle.
REQ-033 rst high in the same cycle as key_valid with code 0x5 -> save1 = 0x0000, S_OP1.
REQ-034 With CALC_BACKSPACE_EN defined, keys 1,2,0xD -> save1 = 0x0001; keys 0xA,0xD -> op = 0, display_state = 00; without the macro, 0xD leaves save1 = 0x0012.
